div_sequencer: RTL
==================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  EX-stage request; sampled only in IDLE.
REQ-004 func3  input  3  M-ext op: 100 DIV, 101 DIVU, 110 REM, 111 REMU; func3[2]=0 means not a divide.
REQ-005 op_a  input  32  dividend (rs1).
REQ-006 op_b  input  32  divisor (rs2).
REQ-007 flush  input  1  pipeline flush; aborts the operation in flight.
REQ-008 busy  output  1  high in CALC, FIX and DONE.
REQ-009 stall  output  1  hold the front pipeline while a divide is pending.
REQ-010 done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-011 result  output  32  quotient or remainder; held until the next accepted op.

Function
REQ-012 States: IDLE, CALC, FIX, DONE; encoded in a registered 2-bit state.
REQ-013 Accept = IDLE & start & func3[2] & ~flush.
- On accept: latch func3, |op_a|, |op_b|, sign flags and special-case flags; clear the 6-bit counter; go to CALC.
REQ-014 start with func3[2]=0 is ignored: no state change, stall low.
REQ-015 CALC performs restoring division on magnitudes, one quotient bit per cycle, 32 cycles (counter 0..31).
- At counter 31, go to FIX.
REQ-016 FIX applies the sign and the special cases, selects the quotient (func3[1]=0) or remainder (func3[1]=1), registers result, then goes to DONE.
REQ-017 Sign rules: quotient negative iff signed op and sign(a)!=sign(b); remainder takes the sign of the dividend; unsigned ops apply no sign change.
REQ-018 Divide by zero: quotient=0xFFFFFFFF and remainder=op_a, for signed and unsigned ops.
REQ-019 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
REQ-020 DONE asserts done for exactly one cycle, then returns to IDLE; start during DONE is ignored.
REQ-021 stall = (state==IDLE & accept-condition ignoring flush) | state==CALC | state==FIX; stall is low in DONE.
REQ-022 Latency: accept in cycle N gives done in cycle N+34 (CALC N+1..N+32, FIX N+33).
REQ-023 flush in any state: next state is IDLE, done stays low, result is unchanged.
- flush wins over a simultaneous start.
REQ-024 A back-to-back start in the cycle after DONE is accepted normally.

Reset
REQ-025 rst_n low: state=IDLE, counter=0, result=0, done=0, busy=0, stall=0, all operand registers 0.
- Reset takes effect immediately, including mid-operation.
REQ-026 After rst_n deasserts, the first possible accept is on the first rising edge.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN is defined: divide-by-zero or signed overflow detected at accept goes IDLE->FIX directly, so done comes at N+2.
REQ-028 Macro DIV_EARLY_OUT_EN is undefined: every op takes the full N+34 latency.
- Results are bit-identical in both builds.

Verification
REQ-029 DIVU 100/7 at N: stall high N..N+33, done at N+34, result=14; REMU of the same operands gives 2.
REQ-030 DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD.
REQ-031 DIV 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0.
- done at N+2 with DIV_EARLY_OUT_EN defined, N+34 without.
REQ-032 flush at N+10 of a DIVU: state IDLE at N+11, no done pulse, result keeps the prior value; a new start at N+11 completes at N+45.
REQ-033 rst_n low at N+20: outputs 0 immediately.
- start with func3=000: no accept, stall low.

Source files
------------

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider sequencer for RV32M DIV/DIVU/REM/REMU
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, func3        EX-stage divide request and M-extension op (func3[2]=1 selects divide)
//   op_a, op_b          dividend (rs1), divisor (rs2)
//   flush               abort the operation in flight and return to IDLE
//   busy                high in CALC, FIX and DONE
//   stall               hold the front pipeline while a divide is pending
//   done                one-cycle pulse, result valid in this cycle
//   result              quotient or remainder, held until the next accepted op
//
// Build option: define DIV_EARLY_OUT_EN to skip CALC for divide-by-zero and
// signed overflow (done two cycles after accept). Results are identical either way.

module div_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,   state_d;
    logic [5:0]  cnt_q,     cnt_d;
    logic        op_rem_q,  op_rem_d;
    logic        a_neg_q,   a_neg_d;
    logic        q_neg_q,   q_neg_d;
    logic        div0_q,    div0_d;
    logic        ovf_q,     ovf_d;
    logic [31:0] a_mag_q,   a_mag_d;
    logic [31:0] b_mag_q,   b_mag_d;
    logic [31:0] quo_q,     quo_d;
    logic [31:0] rem_q,     rem_d;
    logic [31:0] result_q,  result_d;

    logic        is_signed;
    logic        in_a_neg;
    logic        in_b_neg;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;
    logic        in_div0;
    logic        in_ovf;
    logic        div_req;
    logic        accept;
    logic [33:0] trial;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    always_comb begin
        is_signed = ~func3[0];
        in_a_neg  = is_signed & op_a[31];
        in_b_neg  = is_signed & op_b[31];
        in_a_mag  = in_a_neg ? (~op_a + 32'd1) : op_a;
        in_b_mag  = in_b_neg ? (~op_b + 32'd1) : op_b;
        in_div0   = (op_b == 32'd0);
        in_ovf    = is_signed & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
        div_req   = start & func3[2];
        accept    = (state_q == S_IDLE) & div_req & ~flush;

        // Partial remainder shifted left with the next dividend bit; bit 33
        // is the borrow, i.e. the trial subtraction did not fit.
        trial = {1'b0, rem_q, quo_q[31]} - {2'b00, b_mag_q};

        // Divide-by-zero remainder is the original dividend, rebuilt from its
        // magnitude and sign. Overflow falls out of the normal path as well,
        // but is forced so the early-out build needs no CALC pass.
        if (div0_q) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = a_neg_q ? (~a_mag_q + 32'd1) : a_mag_q;
        end else if (ovf_q) begin
            q_fix = 32'h8000_0000;
            r_fix = 32'd0;
        end else begin
            q_fix = q_neg_q ? (~quo_q + 32'd1) : quo_q;
            r_fix = a_neg_q ? (~rem_q + 32'd1) : rem_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_rem_d = op_rem_q;
        a_neg_d  = a_neg_q;
        q_neg_d  = q_neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_rem_d = func3[1];
                    a_neg_d  = in_a_neg;
                    q_neg_d  = in_a_neg ^ in_b_neg;
                    div0_d   = in_div0;
                    ovf_d    = in_ovf;
                    a_mag_d  = in_a_mag;
                    b_mag_d  = in_b_mag;
                    quo_d    = in_a_mag;
                    rem_d    = 32'd0;
                    cnt_d    = 6'd0;
`ifdef DIV_EARLY_OUT_EN
                    state_d  = (in_div0 | in_ovf) ? S_FIX : S_CALC;
`else
                    state_d  = S_CALC;
`endif
                end
            end
            S_CALC: begin
                // quo_q doubles as the dividend shift register: dividend bits
                // leave at the top while quotient bits enter at the bottom.
                if (trial[33]) begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = op_rem_q ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_rem_q <= 1'b0;
            a_neg_q  <= 1'b0;
            q_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_mag_q  <= 32'd0;
            b_mag_q  <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_rem_q <= op_rem_d;
            a_neg_q  <= a_neg_d;
            q_neg_q  <= q_neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // stall rises combinationally with the request so the front end holds
    // in the accept cycle; flush is deliberately not part of that term.
    assign busy   = (state_q != S_IDLE);
    assign stall  = ((state_q == S_IDLE) & div_req) | (state_q == S_CALC) | (state_q == S_FIX);
    assign done   = (state_q == S_DONE) & ~flush;
    assign result = result_q;

endmodule
